// File: rtl/rr_arbiter16.sv
// ---------------------------------------------------------------------------
// rr_arbiter16
//   16-requester round-robin arbiter with registered grants and a bounded
//   hold time. It decides which master owns the shared downstream path.
//   Priority rotates so that no requester starves. The winner is reported
//   as a one-hot grant, a 4-bit index (Y) and a valid flag (Z). The Y/Z
//   pair uses the same index/valid convention as the 16-to-4 priority
//   encoder tree that this block feeds.
//
// Parameters
//   MAX_HOLD : maximum consecutive grant cycles per owner while another
//              request is pending (1..255)
//   CNTW     : hold counter width, 2**CNTW must exceed MAX_HOLD
//
// Ports
//   Clock  in   1   rising-edge clock
//   Resetn in   1   asynchronous active-low reset
//   req    in  16   level-sensitive request vector, bit i = requester i
//   done   in   1   owner finished; only looked at while granting
//   gnt    out 16   registered one-hot grant, zero when Z=0
//   Y      out  4   registered index of the current (or last) owner
//   Z      out  1   registered grant-valid
//   busy   out  1   same as Z
// ---------------------------------------------------------------------------
module rr_arbiter16 #(
   parameter int MAX_HOLD = 15,
   parameter int CNTW     = 8
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic [15:0] req,
   input  logic        done,
   output logic [15:0] gnt,
   output logic [3:0]  Y,
   output logic        Z,
   output logic        busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);

   state_t          state_reg;
   logic [3:0]      ptr_reg;
   logic [CNTW-1:0] hold_cnt_reg;

   logic [15:0] owner_mask;
   logic [15:0] masked_req;
   logic        rel_cond;
   logic        preempt_cond;
   logic [4:0]  pick_idle;
   logic [4:0]  pick_hand;

   // Rotating first-set scan. Walking k from high to low lets the lowest
   // offset from 'start' overwrite the result last, so it wins.
   // Result is {found, index}.
   function automatic logic [4:0] rr_pick(input logic [15:0] v,
                                          input logic [3:0]  start);
      logic [4:0] res;
      logic [3:0] idx;
      res = 5'd0;
      for (int k = 15; k >= 0; k--) begin
         idx = start + 4'(k);
         if (v[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_comb begin
      owner_mask   = 16'd1 << Y;
      masked_req   = req & ~owner_mask;
      rel_cond     = done | ~req[Y];
      preempt_cond = (hold_cnt_reg == HOLD_LAST) && (masked_req != 16'd0);
      pick_idle    = rr_pick(req, ptr_reg);
      // The outgoing owner is excluded from a handoff. The scan restarts
      // just past it, so it drops to lowest priority.
      pick_hand    = rr_pick(masked_req, Y + 4'd1);
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_reg    <= IDLE;
         ptr_reg      <= 4'd0;
         hold_cnt_reg <= '0;
         gnt          <= 16'd0;
         Y            <= 4'd0;
         Z            <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req != 16'd0) begin
                  state_reg    <= GRANT;
                  Y            <= pick_idle[3:0];
                  gnt          <= 16'd1 << pick_idle[3:0];
                  Z            <= 1'b1;
                  hold_cnt_reg <= '0;
               end
            end
            GRANT: begin
               if (rel_cond || preempt_cond) begin
                  ptr_reg <= Y + 4'd1;
                  if (pick_hand[4]) begin
                     // Back-to-back handoff with no idle bubble.
                     Y            <= pick_hand[3:0];
                     gnt          <= 16'd1 << pick_hand[3:0];
                     hold_cnt_reg <= '0;
                  end else begin
                     // Nobody else waiting. Y keeps the last owner.
                     state_reg <= IDLE;
                     gnt       <= 16'd0;
                     Z         <= 1'b0;
                  end
               end else if (hold_cnt_reg != HOLD_LAST) begin
                  hold_cnt_reg <= hold_cnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               gnt       <= 16'd0;
               Z         <= 1'b0;
            end
         endcase
      end
   end

   assign busy = Z;

endmodule

// File: tb/tb_rr_arbiter16.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter16
//   Scoreboard bench for rr_arbiter16 (MAX_HOLD=4). Each driven cycle runs
//   a reference model and queues the expected outputs. The queue is popped
//   and compared one edge later. Directed checks follow the key scenarios:
//   rotation/wrap, full sweep, hold bound, idle pointer, simultaneous
//   events and asynchronous reset. A random section runs at the end.
// ---------------------------------------------------------------------------
module tb_rr_arbiter16;

   localparam int MH = 4;

   logic        Clock;
   logic        Resetn;
   logic [15:0] req;
   logic        done;
   logic [15:0] gnt;
   logic [3:0]  Y;
   logic        Z;
   logic        busy;

   rr_arbiter16 #(.MAX_HOLD(MH), .CNTW(8)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .req    (req),
      .done   (done),
      .gnt    (gnt),
      .Y      (Y),
      .Z      (Z),
      .busy   (busy)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct packed {
      logic [15:0] gnt;
      logic [3:0]  y;
      logic        z;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // reference model state
   logic       m_z;
   logic [3:0] m_y;
   logic [3:0] m_ptr;
   int         m_hold;

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Doubled-vector scan: shift {v,v} so 'start' lands at bit 0 and take
   // the lowest set bit.
   function automatic logic [4:0] ref_pick(input logic [15:0] v,
                                           input logic [3:0]  s);
      logic [31:0] dbl;
      dbl = {v, v} >> s;
      for (int i = 0; i < 16; i++)
         if (dbl[i]) return {1'b1, s + 4'(i)};
      return 5'd0;
   endfunction

   task automatic model_step(input logic [15:0] r, input logic d);
      logic [4:0]  p;
      logic [15:0] others;
      logic        hand;
      if (!m_z) begin
         if (r != 16'd0) begin
            p      = ref_pick(r, m_ptr);
            m_z    = 1'b1;
            m_y    = p[3:0];
            m_hold = 0;
         end
      end else begin
         others = r & ~(16'd1 << m_y);
         hand   = d || !r[m_y] || ((m_hold == MH - 1) && (others != 16'd0));
         if (hand) begin
            p     = ref_pick(others, m_y + 4'd1);
            m_ptr = m_y + 4'd1;
            if (p[4]) begin
               m_y    = p[3:0];
               m_hold = 0;
            end else begin
               m_z = 1'b0;
            end
         end else if (m_hold < MH - 1) begin
            m_hold++;
         end
      end
   endtask

   task automatic run_cycle(input logic [15:0] r, input logic d);
      exp_t e;
      req  = r;
      done = d;
      model_step(r, d);
      e.gnt = m_z ? (16'd1 << m_y) : 16'd0;
      e.y   = m_y;
      e.z   = m_z;
      exp_q.push_back(e);
      @(posedge Clock);
      #1;
      cyc++;
      e = exp_q.pop_front();
      $display("cyc %0d req=%h done=%b -> gnt=%h Y=%0d Z=%b", cyc, r, d, gnt, Y, Z);
      check_val("sb_gnt",  32'(gnt),  32'(e.gnt));
      check_val("sb_y",    32'(Y),    32'(e.y));
      check_val("sb_z",    32'(Z),    32'(e.z));
      check_val("sb_busy", 32'(busy), 32'(e.z));
   endtask

   // Asserts reset between edges. Outputs are checked before any edge, so
   // the drop must come from the reset itself.
   task automatic do_reset();
      Resetn = 1'b0;
      req    = 16'd0;
      done   = 1'b0;
      #2;
      check_val("rst_gnt", 32'(gnt), 32'd0);
      check_val("rst_y",   32'(Y),   32'd0);
      check_val("rst_z",   32'(Z),   32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      m_z    = 1'b0;
      m_y    = 4'd0;
      m_ptr  = 4'd0;
      m_hold = 0;
      @(posedge Clock);
      #2;
      Resetn = 1'b1;
      #2;
   endtask

   initial begin
      Resetn = 1'b0;
      req    = 16'd0;
      done   = 1'b0;
      #1;
      do_reset();

      // Idle with no requests.
      for (int i = 0; i < 5; i++) begin
         run_cycle(16'h0000, 1'b0);
         check_val("idle_z", 32'(Z), 32'd0);
      end

      // Rotation and wrap.
      run_cycle(16'h8001, 1'b0);
      check_val("rot_y0",   32'(Y),   32'd0);
      check_val("rot_gnt0", 32'(gnt), 32'h0001);
      run_cycle(16'h8001, 1'b1);
      check_val("rot_y15",   32'(Y),   32'd15);
      check_val("rot_gnt15", 32'(gnt), 32'h8000);
      run_cycle(16'h8001, 1'b1);
      check_val("rot_wrap", 32'(Y), 32'd0);

      // Reset while a grant is active.
      check_val("pre_rst_z", 32'(Z), 32'd1);
      do_reset();

      // Full sweep with done every cycle.
      run_cycle(16'hFFFF, 1'b0);
      check_val("sweep_y0", 32'(Y), 32'd0);
      for (int i = 1; i <= 16; i++) begin
         run_cycle(16'hFFFF, 1'b1);
         check_val("sweep_y", 32'(Y), 32'(i % 16));
         check_val("sweep_z", 32'(Z), 32'd1);
      end
      do_reset();

      // Hold bound with a competitor pending.
      for (int k = 1; k <= 12; k++) begin
         run_cycle(16'h0003, 1'b0);
         check_val("hold_y", 32'(Y), 32'(((k - 1) / MH) % 2));
      end
      do_reset();

      // A sole requester is never preempted.
      for (int k = 1; k <= 22; k++) begin
         run_cycle(16'h0001, 1'b0);
         check_val("solo_y", 32'(Y), 32'd0);
         check_val("solo_z", 32'(Z), 32'd1);
      end
      do_reset();

      // Release to idle keeps Y; pointer then wraps to 4.
      run_cycle(16'h0020, 1'b0);
      check_val("own5", 32'(Y), 32'd5);
      run_cycle(16'h0000, 1'b0);
      check_val("rel_z",   32'(Z),   32'd0);
      check_val("rel_gnt", 32'(gnt), 32'd0);
      check_val("rel_y",   32'(Y),   32'd5);
      run_cycle(16'h0010, 1'b0);
      check_val("wrap4", 32'(Y), 32'd4);
      do_reset();

      // done together with a new request arriving.
      run_cycle(16'h0008, 1'b0);
      check_val("own3", 32'(Y), 32'd3);
      run_cycle(16'h0088, 1'b1);
      check_val("hand7_y", 32'(Y), 32'd7);
      check_val("hand7_z", 32'(Z), 32'd1);
      do_reset();

      // Random traffic against the model.
      for (int i = 0; i < 300; i++) begin
         logic [15:0] r;
         r = 16'($urandom) & 16'($urandom) & 16'($urandom);
         run_cycle(r, ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arbiter16.md
Name: rr_arbiter16

Overview:
- 16-requester round-robin arbiter with registered grants and a bounded hold time.
- Shares one downstream resource among 16 masters.
- Reports the winner as a one-hot vector, a 4-bit index Y and a valid flag Z, matching the index/valid convention of the 16-to-4 priority encoder tree.
- Sits in front of that encoder/mux datapath. It sequences which requester owns the shared path and rotates priority so that no requester starves.

Parameters:
- MAX_HOLD, 15, maximum consecutive grant cycles per owner while other requests are pending; legal range 1..255.
- CNTW, 8, width of the hold counter; must satisfy 2^CNTW > MAX_HOLD.

Ports:
- Clock  in  1  rising-edge clock
- Resetn  in  1  asynchronous, active-low reset
- req  in  16  request vector; bit i = requester i; level-sensitive
- done  in  1  owner finished; sampled only in GRANT
- gnt  out  16  registered one-hot grant; all-zero when Z=0
- Y  out  4  registered index of current owner
- Z  out  1  registered grant-valid
- busy  out  1  equals Z (state==GRANT)

Behaviour:
- Reset (Resetn=0, asynchronous): state=IDLE, gnt=0, Y=0, Z=0, ptr=0, hold_cnt=0. These values hold until the first rising edge after Resetn rises.
- ptr (4 bits) is the highest-priority index. The winner is the first set bit scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1, mod-16 wrap.
- FSM states: IDLE, GRANT.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise, at the next edge: GRANT, Y=winner, gnt=1<<winner, Z=1, hold_cnt=0.
  - Latency: req to gnt is exactly 1 cycle.
  - done is ignored.
- GRANT, release condition: done=1 OR req[Y]=0.
- GRANT, preempt condition: hold_cnt==MAX_HOLD-1 AND (req with bit Y masked) != 0.
- GRANT, on release or preempt at an edge:
  - ptr <= Y+1 (mod 16).
  - Compute the next winner from req with bit Y masked, starting at Y+1.
  - If a winner exists: stay in GRANT, load the new Y/gnt, hold_cnt=0. Back-to-back handoff with no idle cycle.
  - If no winner: go to IDLE, gnt=0, Z=0; Y keeps its last value.
- GRANT, otherwise: hold the current grant; hold_cnt increments and saturates at MAX_HOLD-1.
- Hold bound: a sole requester with no competitors may hold indefinitely. With a competitor pending throughout, the owner sees Z=1 for exactly MAX_HOLD cycles.
- Simultaneous events: release and preempt in the same cycle are handled identically (one handoff). A new request arriving in the handoff cycle takes part in that cycle's arbitration.
- Invariants: gnt is zero or one-hot; gnt[Y]==Z. Outputs change only on Clock edges or on Resetn assertion.
- Reset mid-grant: all outputs drop immediately (asynchronously) to their reset values; ptr returns to 0.

Test Plan:
- Reset, then req=16'h0000 for 5 cycles -> Z=0, gnt=0, Y=0 throughout. Assert Resetn=0 mid-grant -> gnt=0 and Z=0 immediately, without waiting for an edge.
- After reset, req=16'h8001 -> one cycle later Y=0, gnt=16'h0001. Pulse done -> next cycle Y=15, gnt=16'h8000. Pulse done again -> Y=0. Confirms rotation and wrap.
- req=16'hFFFF held, done pulsed every cycle -> Y steps 0, 1, 2, ..., 15, 0 on consecutive cycles with Z never dropping.
- MAX_HOLD=4, req=16'h0003 held, done=0 -> Y=0 for exactly 4 cycles, then Y=1 for 4 cycles, then Y=0. Same setup with req=16'h0001 -> Y=0 held for 20+ cycles, no preemption.
- Grant to 5 (req=16'h0020), then drop req[5] with req=0 -> next cycle Z=0, gnt=0, Y=5. Then req=16'h0010 -> Y=4, since ptr=6 and the scan wraps to 4.
- Owner Y=3 asserts done in the same cycle req[7] rises, with no other requests -> next cycle Y=7, Z stays 1.
